// File: rtl/norm_pkg.sv
// norm_pkg: shared definitions for the normalise/round pipeline.
//   - default widths for the accumulator sum, stored fraction and exponent
//   - CNT_W: width of the optional statistics counters
//   - lead_one(): index of the highest set bit, limited to a given width
//   - round_up(): round-to-nearest-even decision from guard/sticky/lsb
package norm_pkg;

    localparam int SUM_W_DEF = 20;
    localparam int MAN_W_DEF = 11;
    localparam int EXP_W_DEF = 6;
    localparam int CNT_W     = 16;

    // Highest set bit among the low w bits of v; returns 0 for a zero value
    // (callers flag zero separately).
    function automatic int lead_one(input logic [63:0] v, input int w);
        int idx;
        idx = 0;
        for (int i = 0; i < 64; i++) begin
            if (i < w && v[i]) idx = i;
        end
        return idx;
    endfunction

    // Round half to even: a tie (guard set, nothing below) only rounds up
    // when the kept lsb is odd.
    function automatic logic round_up(input logic guard, input logic sticky,
                                      input logic lsb);
        return guard & (sticky | lsb);
    endfunction

endpackage

// File: rtl/norm_stats.sv
// norm_stats: saturating event counters for the normaliser output stream.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clr          synchronous clear; wins over a coincident increment
//   beat         an output transfer happened this cycle
//   carry        the transferred result had a rounding carry
//   inexact      the transferred result was inexact
//   cnt_beats, cnt_carry, cnt_inexact   CNT_W-bit counters, stick at all-ones
module norm_stats
    import norm_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             beat,
    input  logic             carry,
    input  logic             inexact,
    output logic [CNT_W-1:0] cnt_beats,
    output logic [CNT_W-1:0] cnt_carry,
    output logic [CNT_W-1:0] cnt_inexact
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                                  input logic en);
        if (en && (c != '1)) return c + CNT_W'(1);
        return c;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_beats   <= '0;
            cnt_carry   <= '0;
            cnt_inexact <= '0;
        end else if (clr) begin
            cnt_beats   <= '0;
            cnt_carry   <= '0;
            cnt_inexact <= '0;
        end else begin
            cnt_beats   <= sat_inc(cnt_beats, beat);
            cnt_carry   <= sat_inc(cnt_carry, beat & carry);
            cnt_inexact <= sat_inc(cnt_inexact, beat & inexact);
        end
    end

endmodule

// File: rtl/norm_round_pipe.sv
// norm_round_pipe: two-stage normaliser with round-to-nearest-even.
// Converts a signed accumulator sum plus block exponent into sign, hidden-one
// fraction and exponent, with zero and inexact flags, behind a valid/ready
// handshake with full backpressure (the whole pipe stalls together).
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          input handshake
//   in_sum [SUM_W]             signed sum
//   in_exp [EXP_W]             signed block exponent
//   out_valid/out_ready        output handshake
//   out_sign, out_frac[MAN_W], out_exp[EXP_OUT_W], out_zero, out_inexact
// Optional build macro NORM_CNT_EN adds cnt_clr and the 16-bit counters
// cnt_beats / cnt_carry / cnt_inexact (norm_stats sub-block).
module norm_round_pipe
    import norm_pkg::*;
#(
    parameter int SUM_W     = SUM_W_DEF,
    parameter int MAN_W     = MAN_W_DEF,
    parameter int EXP_W     = EXP_W_DEF,
    parameter int EXP_OUT_W = EXP_W + 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [SUM_W-1:0]     in_sum,
    input  logic signed [EXP_W-1:0]     in_exp,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_sign,
    output logic [MAN_W-1:0]            out_frac,
    output logic signed [EXP_OUT_W-1:0] out_exp,
    output logic                        out_zero,
    output logic                        out_inexact
`ifdef NORM_CNT_EN
    ,
    input  logic                        cnt_clr,
    output logic [CNT_W-1:0]            cnt_beats,
    output logic [CNT_W-1:0]            cnt_carry,
    output logic [CNT_W-1:0]            cnt_inexact
`endif
);

    localparam int LEAD_W = $clog2(SUM_W);

    // One advance signal for both stages; S1 slides into an empty S2 even
    // while downstream is stalled.
    assign in_ready = ~out_valid | out_ready;

    // ---------------- stage 1: sign, magnitude, leading one ----------------
    logic [SUM_W-1:0]        mag_c;
    logic                    vld_p1;
    logic                    sign_p1;
    logic                    zero_p1;
    logic [SUM_W-1:0]        mag_p1;
    logic [LEAD_W-1:0]       lead_p1;
    logic signed [EXP_W-1:0] exp_p1;

    // Negating the most-negative value wraps to 2^(SUM_W-1), which is the
    // correct unsigned magnitude.
    assign mag_c = in_sum[SUM_W-1] ? SUM_W'(-in_sum) : SUM_W'(in_sum);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_p1 <= 1'b0;
        else if (in_ready) vld_p1 <= in_valid;
    end

    always_ff @(posedge clk) begin
        if (in_ready) begin
            sign_p1 <= in_sum[SUM_W-1];
            zero_p1 <= (mag_c == '0);
            mag_p1  <= mag_c;
            lead_p1 <= LEAD_W'(lead_one(64'(mag_c), SUM_W));
            exp_p1  <= in_exp;
        end
    end

    // ---------------- stage 2: align, round, exponent ----------------
    // Shifting the leading one up to the MSB covers both the truncating case
    // and the short (left-aligned, zero-padded) case with one slice.
    logic [SUM_W-1:0]            norm_c;
    logic [MAN_W-1:0]            frac_c;
    logic                        guard_c;
    logic                        sticky_c;
    logic [MAN_W:0]              rsum_c;
    logic                        carry_c;
    int                          e_c;
    logic signed [EXP_OUT_W-1:0] exp_c;

    always_comb begin
        norm_c   = mag_p1 << (SUM_W - 1 - int'(lead_p1));
        frac_c   = norm_c[SUM_W-2 -: MAN_W];
        guard_c  = norm_c[SUM_W-2-MAN_W];
        sticky_c = |norm_c[SUM_W-3-MAN_W:0];
        rsum_c   = {1'b0, frac_c}
                 + {{MAN_W{1'b0}}, round_up(guard_c, sticky_c, frac_c[0])};
        // All-ones fraction rounding up wraps to zero and bumps the exponent.
        carry_c  = rsum_c[MAN_W];
        e_c      = int'(exp_p1) + int'(lead_p1) - MAN_W + int'(carry_c);
        exp_c    = e_c[EXP_OUT_W-1:0];
    end

`ifdef NORM_CNT_EN
    logic carry_p2;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_sign    <= 1'b0;
            out_frac    <= '0;
            out_exp     <= '0;
            out_zero    <= 1'b0;
            out_inexact <= 1'b0;
`ifdef NORM_CNT_EN
            carry_p2    <= 1'b0;
`endif
        end else if (in_ready) begin
            out_valid <= vld_p1;
            if (zero_p1) begin
                out_sign    <= 1'b0;
                out_frac    <= '0;
                out_exp     <= '0;
                out_zero    <= 1'b1;
                out_inexact <= 1'b0;
`ifdef NORM_CNT_EN
                carry_p2    <= 1'b0;
`endif
            end else begin
                out_sign    <= sign_p1;
                out_frac    <= rsum_c[MAN_W-1:0];
                out_exp     <= exp_c;
                out_zero    <= 1'b0;
                out_inexact <= guard_c | sticky_c;
`ifdef NORM_CNT_EN
                carry_p2    <= carry_c;
`endif
            end
        end
    end

`ifdef NORM_CNT_EN
    norm_stats u_stats (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (cnt_clr),
        .beat        (out_valid & out_ready),
        .carry       (carry_p2),
        .inexact     (out_inexact),
        .cnt_beats   (cnt_beats),
        .cnt_carry   (cnt_carry),
        .cnt_inexact (cnt_inexact)
    );
`endif

endmodule

// File: tb/tb_norm_round_pipe.sv
// tb_norm_round_pipe: directed table, backpressure / reset sequences and a
// randomized stream checked against an arithmetic reference model.
// Build macro NORM_CNT_EN additionally exercises the statistics counters.
module tb_norm_round_pipe;
    import norm_pkg::*;

    localparam int SUM_W = 20, MAN_W = 11, EXP_W = 6, EXP_OUT_W = 7;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic                        in_valid;
    logic                        in_ready;
    logic signed [SUM_W-1:0]     in_sum;
    logic signed [EXP_W-1:0]     in_exp;
    logic                        out_valid;
    logic                        out_ready;
    logic                        out_sign;
    logic [MAN_W-1:0]            out_frac;
    logic signed [EXP_OUT_W-1:0] out_exp;
    logic                        out_zero;
    logic                        out_inexact;
`ifdef NORM_CNT_EN
    logic                        cnt_clr;
    logic [15:0]                 cnt_beats, cnt_carry, cnt_inexact;
`endif

    always #5 clk = ~clk;

    norm_round_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sum(in_sum), .in_exp(in_exp),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_frac(out_frac), .out_exp(out_exp),
        .out_zero(out_zero), .out_inexact(out_inexact)
`ifdef NORM_CNT_EN
        , .cnt_clr(cnt_clr), .cnt_beats(cnt_beats),
        .cnt_carry(cnt_carry), .cnt_inexact(cnt_inexact)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    endtask

    typedef struct {
        bit sign;
        int frac;
        int e;
        bit zero;
        bit inexact;
        bit carry;
    } res_t;

    // Reference: exact integer arithmetic on the magnitude, independent of
    // any bit-slicing scheme.
    function automatic res_t model(input logic [SUM_W-1:0] sum, input int ein);
        res_t   r;
        longint s, mag, q, rem, half;
        int     lead, sh;
        r = '{0, 0, 0, 0, 0, 0};
        s   = longint'($signed(sum));
        mag = (s < 0) ? -s : s;
        if (mag == 0) begin
            r.zero = 1;
            return r;
        end
        lead = 0;
        while ((mag >> (lead + 1)) != 0) lead++;
        sh = lead - MAN_W;
        if (sh <= 0) begin
            q   = mag << (-sh);
            rem = 0;
        end else begin
            q    = mag >> sh;
            rem  = mag - (q << sh);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
        end
        if (q == (longint'(2) << MAN_W)) begin
            q = q / 2;
            r.carry = 1;
        end
        r.sign    = (s < 0);
        r.frac    = int'(q - (longint'(1) << MAN_W));
        r.e       = ein + sh + int'(r.carry);
        r.inexact = (rem != 0);
        return r;
    endfunction

    // ---------------- scoreboard / stability monitor ----------------
    res_t sb_q[$];
    bit   hold_pend = 0;
    logic h_sign, h_zero, h_inex;
    logic [MAN_W-1:0] h_frac;
    logic signed [EXP_OUT_W-1:0] h_exp;

    always @(negedge clk) begin
        res_t r;
        if (!rst_n) begin
            hold_pend = 0;
        end else begin
            if (hold_pend && out_valid) begin
                check("hold_stable",
                      longint'({h_sign, h_frac, h_exp, h_zero, h_inex}),
                      longint'({out_sign, out_frac, out_exp, out_zero, out_inexact}));
            end
            hold_pend = out_valid && !out_ready;
            h_sign = out_sign; h_frac = out_frac; h_exp = out_exp;
            h_zero = out_zero; h_inex = out_inexact;
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_output", 1, 0);
                end else begin
                    r = sb_q.pop_front();
                    check("sb_sign", longint'(out_sign), longint'(r.sign));
                    check("sb_frac", longint'(out_frac), longint'(r.frac));
                    check("sb_exp", longint'(int'(out_exp)), longint'(r.e));
                    check("sb_zero", longint'(out_zero), longint'(r.zero));
                    check("sb_inexact", longint'(out_inexact), longint'(r.inexact));
                end
            end
            if (in_valid && in_ready) sb_q.push_back(model(in_sum, int'(in_exp)));
        end
    end

    // ---------------- directed table ----------------
    typedef struct {
        logic [SUM_W-1:0] sum;
        int               ein;
        res_t             req;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs[NV];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, seen, exp_carry, exp_inex, idx, cyc;
        bit acc;
        logic [SUM_W-1:0] bp_sum[6];
        int bp_exp[6];

        vecs[0] = '{20'h00800,   0, '{0, 'h000,   0, 0, 0, 0}};
        vecs[1] = '{20'h80000,   0, '{1, 'h000,   8, 0, 0, 0}};
        vecs[2] = '{20'h01FFF,   3, '{0, 'h000,   5, 0, 1, 1}};
        vecs[3] = '{20'h01003,   0, '{0, 'h002,   1, 0, 1, 0}};
        vecs[4] = '{20'h01001,   0, '{0, 'h000,   1, 0, 1, 0}};
        vecs[5] = '{20'h00000,   5, '{0, 'h000,   0, 1, 0, 0}};
        vecs[6] = '{20'hFFFFF,   0, '{1, 'h000, -11, 0, 0, 0}};
        vecs[7] = '{20'h7FFFF, -32, '{0, 'h000, -24, 0, 1, 1}};
        vecs[8] = '{20'hFEFFD,   0, '{1, 'h002,   1, 0, 1, 0}};
        vecs[9] = '{20'h00C00,   2, '{0, 'h400,   2, 0, 0, 0}};

        rst_n = 1'b0; in_valid = 1'b0; in_sum = '0; in_exp = '0; out_ready = 1'b0;
`ifdef NORM_CNT_EN
        cnt_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_in_ready", longint'(in_ready), 1);
        check("rst_out_frac", longint'(out_frac), 0);
        check("rst_out_exp", longint'(int'(out_exp)), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // One beat at a time: latency and table values.
        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            in_valid = 1'b1;
            in_sum   = vecs[i].sum;
            in_exp   = EXP_W'(vecs[i].ein);
            lat = 0;
            seen = 0;
            while (lat < 10 && seen == 0) begin
                @(posedge clk); #1;
                lat++;
                in_valid = 1'b0;
                if (out_valid) seen = 1;
            end
            check($sformatf("v%0d_latency", i), longint'(seen ? lat : -1), 2);
            check($sformatf("v%0d_sign", i), longint'(out_sign), longint'(vecs[i].req.sign));
            check($sformatf("v%0d_frac", i), longint'(out_frac), longint'(vecs[i].req.frac));
            check($sformatf("v%0d_exp", i), longint'(int'(out_exp)), longint'(vecs[i].req.e));
            check($sformatf("v%0d_zero", i), longint'(out_zero), longint'(vecs[i].req.zero));
            check($sformatf("v%0d_inexact", i), longint'(out_inexact),
                  longint'(vecs[i].req.inexact));
        end
        repeat (2) @(posedge clk);
        #1;
`ifdef NORM_CNT_EN
        exp_carry = 0; exp_inex = 0;
        for (int i = 0; i < NV; i++) begin
            exp_carry += int'(vecs[i].req.carry);
            exp_inex  += int'(vecs[i].req.inexact);
        end
        check("cnt_beats", longint'(cnt_beats), NV);
        check("cnt_carry", longint'(cnt_carry), exp_carry);
        check("cnt_inexact", longint'(cnt_inexact), exp_inex);
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        check("cnt_clr_beats", longint'(cnt_beats), 0);
        check("cnt_clr_carry", longint'(cnt_carry), 0);
        check("cnt_clr_inexact", longint'(cnt_inexact), 0);
`else
        exp_carry = 0; exp_inex = 0;
`endif

        // Backpressure: 6 beats, out_ready low for the first 4 cycles.
        bp_sum[0] = 20'h00800; bp_exp[0] = 1;
        bp_sum[1] = 20'h00000; bp_exp[1] = 7;
        bp_sum[2] = 20'h12345; bp_exp[2] = -3;
        bp_sum[3] = 20'hABCDE; bp_exp[3] = 10;
        bp_sum[4] = 20'h01001; bp_exp[4] = 0;
        bp_sum[5] = 20'h00003; bp_exp[5] = -20;
        idx = 0;
        cyc = 0;
        while (idx < 6 && cyc < 40) begin
            out_ready = (cyc >= 4);
            in_valid  = 1'b1;
            in_sum    = bp_sum[idx];
            in_exp    = EXP_W'(bp_exp[idx]);
            #1;
            if (cyc < 2) check($sformatf("bp_in_ready_c%0d", cyc), longint'(in_ready), 1);
            if (cyc == 2 || cyc == 3) check($sformatf("bp_in_ready_c%0d", cyc),
                                            longint'(in_ready), 0);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            cyc++;
        end
        check("bp_all_accepted", idx, 6);
        in_valid = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (sb_q.size() != 0 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        @(posedge clk); #1;
        check("bp_drained", sb_q.size(), 0);
        check("bp_idle", longint'(out_valid), 0);

        // Randomized stream with random stalls.
        for (int c = 0; c < 800; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 5))
                0:       in_sum = '0;
                1:       in_sum = 20'h80000;
                2:       in_sum = SUM_W'($urandom_range(0, 8191));
                3:       in_sum = -SUM_W'($urandom_range(0, 8191));
                default: in_sum = SUM_W'($urandom);
            endcase
            in_exp = EXP_W'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (sb_q.size() != 0 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("rand_drained", sb_q.size(), 0);

        // Reset with two beats in flight.
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_sum   = SUM_W'(20'h00A55 + k);
            in_exp   = EXP_W'(k);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("rst_mid_pre_valid", longint'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", longint'(out_valid), 0);
        check("rst_mid_out_frac", longint'(out_frac), 0);
        check("rst_mid_out_inexact", longint'(out_inexact), 0);
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("rst_no_stale", seen, 0);
        check("rst_in_ready_after", longint'(in_ready), 1);
`ifdef NORM_CNT_EN
        check("rst_cnt_beats", longint'(cnt_beats), 0);
        check("rst_cnt_carry", longint'(cnt_carry), 0);
        check("rst_cnt_inexact", longint'(cnt_inexact), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/norm_round_pipe.md
# norm_round_pipe

Pipelined, parametrised successor to the MAC's combinational normalizer. It takes a signed two's-complement accumulator sum and a block exponent, and produces sign, fraction and exponent with correct round-to-nearest-even using guard and sticky bits. Zero results are flagged explicitly. It sits between the SD4 MAC accumulator and the output formatter, with a valid/ready handshake and full backpressure.

## Interface
- SUM_W, 20: accumulator sum width, signed.
- MAN_W, 11: stored fraction width; the leading one is implicit and not output.
- EXP_W, 6: input exponent width, signed.
- EXP_OUT_W, EXP_W+1: output exponent width, signed. It must be wide enough for the full exponent range; no check is made.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_sum  in  SUM_W  signed sum.
- in_exp  in  EXP_W  signed block exponent.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_sign  out  1  result sign.
- out_frac  out  MAN_W  fraction bits below the leading one.
- out_exp  out  EXP_OUT_W  signed result exponent.
- out_zero  out  1  magnitude was zero.
- out_inexact  out  1  any nonzero bits were discarded.

## Operation
- Stage 1 (S1):
  - Register the sign, the magnitude (SUM_W bits unsigned) and the exponent.
  - Magnitude is the two's-complement negation when sign=1. The most-negative input gives magnitude 2^(SUM_W-1) exactly.
  - Compute `lead` = index of the highest set bit of the magnitude (priority detector).
- Stage 2 (S2):
  - If lead > MAN_W: frac = mag[lead-1 : lead-MAN_W]; guard = mag[lead-MAN_W-1] (0 if lead == MAN_W); sticky = OR of the bits below the guard.
  - If lead ≤ MAN_W: frac = mag[lead-1:0] left-aligned and zero-padded; guard = sticky = 0.
  - Rounding is RNE: round up when guard & (sticky | frac[0]).
  - If frac is all ones and rounds up: frac becomes 0 and carry = 1.
  - out_exp = sign-extended in_exp + (lead − MAN_W) + carry.
  - out_inexact = guard | sticky.
- Zero magnitude: out_zero=1, out_sign=0, out_frac=0, out_exp=0, out_inexact=0.
- Output sign follows the input sign bit for every nonzero result.

## Timing
- Latency is 2 cycles, input acceptance to out_valid, when there is no backpressure.
- Throughput is 1 beat per cycle.
- Handshake:
  - A transfer occurs on any cycle where valid & ready are both high.
  - Once out_valid is asserted, the output data stays stable until it is accepted.
- Stall: the whole pipe stalls together. in_ready = ~S2_valid | out_ready, with bubbles collapsing.
  - Concretely: S1 advances into an empty S2 even while out_ready=0.
- A simultaneous accept and new input in the same cycle sustains full rate with no lost beat.
- Reset:
  - All valid bits, out_valid and every output clear to 0 asynchronously.
  - in_ready is 1 after reset.
  - In-flight beats are dropped.
  - Data registers need not be reset.

## Configuration
- NORM_CNT_EN defined: adds a stats sub-block with the following outputs.
  - cnt_beats (16 bits) counts output transfers.
  - cnt_carry (16 bits) counts round carries.
  - cnt_inexact (16 bits) counts inexact results.
  - All counters saturate at 0xFFFF, reset to 0, and clear synchronously on input cnt_clr.
  - If cnt_clr coincides with an increment, clear wins.
- NORM_CNT_EN undefined: these ports and all counter logic are absent, and the datapath is unchanged.

## Structure
- Shared package `norm_pkg`:
  - Default widths.
  - A leading-one function parametrised by width.
  - The round-decision function.
- One sub-module: `norm_stats`, the saturating counters, instantiated only under NORM_CNT_EN.

## Test plan
All scenarios use default parameters.
- Exact alignment: sum=20'h00800, exp=0 -> frac=0, exp=0, sign=0, inexact=0, 2 cycles after acceptance.
- Most-negative input: sum=20'h80000, exp=0 -> sign=1, frac=0, exp=8, inexact=0.
- Carry case: sum=20'h01FFF, exp=3 -> frac=0, exp=5, inexact=1; cnt_carry increments when NORM_CNT_EN is defined.
- Tie to even:
  - sum=20'h01003 -> frac=11'h002, exp=1.
  - sum=20'h01001 -> frac=0, exp=1.
  - Both give inexact=1.
- Zero and backpressure:
  - Stream 6 beats with out_ready held low for 4 cycles.
  - Expect in_ready to drop after 2 beats are held.
  - All outputs in order with no duplicates.
  - A sum=0 beat yields out_zero=1, exp=0.
- Reset mid-stream: assert rst_n low with 2 beats in flight -> out_valid=0 immediately, no stale output after release, and counters are 0.
